// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// ---------------------------------------------------------------------------
// Parametrised universal shift register. Each enabled cycle performs one of
// four operations: hold, shift left, shift right or parallel load. The
// register has serial I/O at both ends, so it can be used for serial capture
// (SIPO), serial transmit (PISO) and bit reversal. A shift counter tracks
// progress through a WIDTH-bit frame and raises a one-cycle frame_done pulse
// once the frame is complete.
//
// Optional feature (compile-time macro): UNIV_SHIFT_ROTATE_EN
//   Defined   : when rot=1, shifts recirculate the bit that leaves the
//               register instead of taking sin_l/sin_r. The counter and
//               frame_done behave exactly as they do for plain shifts.
//   Undefined : the rot port is kept but ignored, and no rotate logic is
//               built.
//
// Parameters
//   WIDTH     register width in bits (2..64)
//   RST_VAL   value loaded into q on reset
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         cycle enable; en=0 forces hold
//   mode       00 hold, 01 shift left, 10 shift right, 11 parallel load
//   sin_l      serial input entering q[0] on shift left
//   sin_r      serial input entering q[WIDTH-1] on shift right
//   rot        rotate request (used only with UNIV_SHIFT_ROTATE_EN)
//   load_data  parallel load value
//   q          register contents
//   sout_l     q[WIDTH-1], the bit leaving on shift left
//   sout_r     q[0], the bit leaving on shift right
//   shift_cnt  shifts performed since the last load, reset or wrap
//   frame_done one-cycle pulse while q holds a completed WIDTH-shift frame
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     sin_l,
  input  logic                     sin_r,
  input  logic                     rot,
  input  logic [WIDTH-1:0]         load_data,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_l,
  output logic                     sout_r,
  output logic [$clog2(WIDTH)-1:0] shift_cnt,
  output logic                     frame_done
);

  localparam int CW = $clog2(WIDTH);

  // Compare against WIDTH-1 explicitly, so that widths which are not a power
  // of two still wrap after exactly WIDTH shifts.
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHL   = 2'b01,
    MODE_SHR   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  mode_t mode_e;
  logic  fill_l;
  logic  fill_r;
  logic  do_shift;

  assign mode_e   = mode_t'(mode);
  assign do_shift = en && ((mode_e == MODE_SHL) || (mode_e == MODE_SHR));

`ifdef UNIV_SHIFT_ROTATE_EN
  // Rotation recirculates the bit that is about to fall off the opposite end.
  always_comb begin
    fill_l = sin_l;
    fill_r = sin_r;
    if (rot) begin
      fill_l = q[WIDTH-1];
      fill_r = q[0];
    end
  end
`else
  logic rot_unused;

  assign fill_l     = sin_l;
  assign fill_r     = sin_r;
  assign rot_unused = rot;
`endif

  // The data register and the frame counter are updated together. A load
  // clears the counter, which abandons any partial frame. frame_done
  // defaults low, so each pulse lasts exactly one cycle, and it is
  // registered so that it lines up with q holding the finished frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q          <= RST_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        case (mode_e)
          MODE_SHL:  q <= {q[WIDTH-2:0], fill_l};
          MODE_SHR:  q <= {fill_r, q[WIDTH-1:1]};
          MODE_LOAD: begin
            q         <= load_data;
            shift_cnt <= '0;
          end
          default:   q <= q;
        endcase
      end
      if (do_shift) begin
        if (shift_cnt == CNT_LAST) begin
          shift_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          shift_cnt <= shift_cnt + CW'(1);
        end
      end
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register with per-cycle mode select (hold, shift left, shift right, parallel load). It has serial I/O at both ends and a shift counter that flags each completed WIDTH-bit frame. It is the general-purpose successor to the fixed 8-bit left-shift register, used for serial capture (SIPO), serial transmit (PISO) and bit-reversal paths in the datapath.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  cycle enable; en=0 forces hold regardless of mode.
- mode  in  2  operation: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- sin_l  in  1  serial input entering q[0] on shift left.
- sin_r  in  1  serial input entering q[WIDTH-1] on shift right.
- rot  in  1  rotate request; see Configuration.
- load_data  in  WIDTH  parallel load value.
- q  out  WIDTH  register contents.
- sout_l  out  1  combinational q[WIDTH-1], the bit leaving on shift left.
- sout_r  out  1  combinational q[0], the bit leaving on shift right.
- shift_cnt  out  $clog2(WIDTH)  shifts performed since the last load, reset or wrap.
- frame_done  out  1  one-cycle pulse marking a completed WIDTH-shift frame.

## Operation
- Reset (asynchronous, any time, including mid-frame): q=RST_VAL, shift_cnt=0, frame_done=0. These values hold until the first clock edge after rst deasserts.
- Hold (en=0 or mode=00): q and shift_cnt unchanged; frame_done=0 next cycle.
- Shift left (en=1, mode=01): q <= {q[WIDTH-2:0], sin_l}.
- Shift right (en=1, mode=10): q <= {sin_r, q[WIDTH-1:1]}.
- Both shift modes:
  - shift_cnt increments.
  - When shift_cnt==WIDTH-1 before the edge, shift_cnt wraps to 0 and frame_done is set for the next cycle.
  - Direction changes mid-frame do not reset the count.
- Parallel load (en=1, mode=11): q <= load_data, shift_cnt <= 0, frame_done <= 0. A load aborts any partial frame.
- frame_done is registered. It is high exactly in the cycle after the edge that performed the WIDTH-th shift, so it coincides with q holding the completed frame. Back-to-back frames give a pulse every WIDTH shifting cycles.
- sout_l and sout_r are pure functions of q and carry no added latency.

## Timing
- Latency: mode/data to q is 1 clock edge; to frame_done is 1 edge after the final shift.
- All inputs are sampled on the rising clk edge only. No combinational path exists from any input to any output.
- Throughput: one operation per cycle, with no stall or backpressure.
- Boundary cases:
  - Wrap occurs at shift_cnt WIDTH-1 -> 0.
  - A load on the cycle after the WIDTH-th shift does not cancel the frame_done already registered.
  - rst asserted at the same edge as any operation wins.

## Configuration
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined:
  - With rot=1, shift left feeds q[WIDTH-1] into q[0] instead of sin_l.
  - With rot=1, shift right feeds q[0] into q[WIDTH-1] instead of sin_r.
  - Counter and frame_done behave identically to plain shifts.
- Not defined:
  - The rot port remains present but is ignored.
  - Shifts always use sin_l/sin_r.
  - No rotate logic is synthesised.

## Test plan
- Reset: WIDTH=8, RST_VAL=8'hA5; assert rst asynchronously mid-cycle -> q=8'hA5, shift_cnt=0 and frame_done=0 immediately, without waiting for a clock.
- SIPO: 8 shift-left cycles with sin_l sequence 1,0,1,1,0,0,1,0 -> q=8'hB2; frame_done high for exactly one cycle after the 8th edge; shift_cnt=0.
- PISO: load 8'h81, then 8 shift-right cycles with sin_r=0 -> sout_r sequence 1,0,0,0,0,0,0,1; final q=8'h00; one frame_done pulse.
- Abort and hold: load 8'hFF, 3 shifts, 2 cycles with en=0 (q and shift_cnt=3 held), then load 8'h0F -> shift_cnt=0, q=8'h0F, no frame_done.
- Rotate (macro defined): load 8'h01, rot=1, 9 shift-left cycles -> q=8'h02; frame_done pulse after the 8th shift, when q=8'h01.
- Rotate (macro undefined): same stimulus with sin_l=0 -> q=8'h00 after the 8th shift; rot has no effect.
